// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Port-B read master for ram_d. On start it reads `length` words from
//   `base_addr` upward (address wraps modulo 2^addr_bits) and presents them
//   as a valid/ready stream, flagging the final word with m_last.
//
//   Data path: dob -> 2-entry buffer -> output register (m_data/m_valid).
//   The buffer is bypassed when the output register is free, so the first
//   word reaches m_valid two edges after start is sampled.
//
//   ben is a registered output. Its value is chosen one edge before the read
//   it describes, so the decision cannot see the downstream ready of the
//   cycle the data arrives in. Three reads can be owed at once (one
//   presented, one on dob, one being issued), and the output register plus
//   the 2-entry buffer hold exactly three. A read is issued only if the
//   words held after this edge, plus the read already on the RAM port,
//   leave a free slot. This sustains one word per cycle with m_ready held
//   high and cannot overflow under any backpressure pattern.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin a transfer (sampled only in IDLE)
//   base_addr, length   first address / word count 0..2^addr_bits, sampled with start
//   busy, done          registered status; done is a 1-cycle pulse, coincident with busy
//   ben, addrb          RAM port-B read enable / address (addrb holds when ben=0)
//   dob                 RAM port-B read data, valid 1 cycle after ben
//   m_valid, m_ready    output stream handshake
//   m_data, m_last      output word, high on the final word of the transfer
module ram_stream_reader #(
  parameter int addr_bits = 8,
  parameter int data_bits = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addr_bits-1:0] base_addr,
  input  logic [addr_bits:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 ben,
  output logic [addr_bits-1:0] addrb,
  input  logic [data_bits-1:0] dob,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [data_bits-1:0] m_data,
  output logic                 m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [addr_bits:0]   cnt_one  = 1;
  localparam logic [addr_bits-1:0] addr_one = 1;

  state_t                 state_reg, state_next;
  logic [addr_bits:0]     len_reg;
  logic [addr_bits:0]     issue_cnt_reg;   // reads issued so far
  logic [addr_bits:0]     acc_cnt_reg;     // words accepted downstream so far
  logic                   ben_reg, ben_next;
  logic [addr_bits-1:0]   addr_reg;
  logic                   pend_reg;        // dob carries a requested word this cycle
  logic                   out_valid_reg;
  logic [data_bits-1:0]   out_data_reg;
  logic [data_bits-1:0]   fifo_mem [0:1];
  logic                   fifo_rd_reg, fifo_wr_reg;
  logic [1:0]             fifo_cnt_reg;
  logic                   busy_reg, done_reg;

  logic                   pop;
  logic                   last_word;
  logic                   load_out;
  logic                   fifo_push, fifo_pop;
  logic [2:0]             held_next;

  assign pop       = out_valid_reg & m_ready;
  assign last_word = out_valid_reg && (acc_cnt_reg == len_reg - cnt_one);

  // The output register refills whenever it is empty or being accepted;
  // it prefers the older buffered word, otherwise takes dob directly.
  assign load_out  = !out_valid_reg || pop;
  assign fifo_pop  = load_out && (fifo_cnt_reg != 2'd0);
  assign fifo_push = pend_reg && !(load_out && (fifo_cnt_reg == 2'd0));

  // Words held (output register + buffer) after the coming edge.
  assign held_next = 3'(out_valid_reg) + 3'(fifo_cnt_reg) + 3'(pend_reg) - 3'(pop);

  always_comb begin
    state_next = state_reg;
    ben_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_next = READ;
            ben_next   = 1'b1;
          end else begin
            state_next = FINISH;
          end
        end
      end
      READ: begin
        if (issue_cnt_reg == len_reg) begin
          state_next = DRAIN;
        end else begin
          // ben_reg is the read whose data lands one edge later.
          ben_next = (held_next + 3'(ben_reg)) < 3'd3;
        end
      end
      DRAIN: begin
        if (pop && last_word) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      acc_cnt_reg   <= '0;
      ben_reg       <= 1'b0;
      addr_reg      <= '0;
      pend_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      fifo_rd_reg   <= 1'b0;
      fifo_wr_reg   <= 1'b0;
      fifo_cnt_reg  <= 2'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      ben_reg   <= ben_next;
      pend_reg  <= ben_reg;
      busy_reg  <= (state_reg != IDLE);
      done_reg  <= (state_reg == FINISH);

      if (state_reg == IDLE && start) begin
        addr_reg      <= base_addr;
        len_reg       <= length;
        issue_cnt_reg <= (length != '0) ? cnt_one : '0;
        acc_cnt_reg   <= '0;
      end else begin
        if (ben_next) begin
          addr_reg      <= addr_reg + addr_one;
          issue_cnt_reg <= issue_cnt_reg + cnt_one;
        end
        if (pop) acc_cnt_reg <= acc_cnt_reg + cnt_one;
      end

      if (load_out) begin
        if (fifo_cnt_reg != 2'd0) begin
          out_data_reg  <= fifo_mem[fifo_rd_reg];
          out_valid_reg <= 1'b1;
        end else if (pend_reg) begin
          out_data_reg  <= dob;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;   // m_data keeps its last value
        end
      end

      if (fifo_push) fifo_wr_reg <= ~fifo_wr_reg;
      if (fifo_pop)  fifo_rd_reg <= ~fifo_rd_reg;
      fifo_cnt_reg <= fifo_cnt_reg + 2'(fifo_push) - 2'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wr_reg] <= dob;
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign ben     = ben_reg;
  assign addrb   = addr_reg;
  assign m_valid = out_valid_reg;
  assign m_data  = out_data_reg;
  assign m_last  = last_word;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a table of transfers (base, length, ready
// pattern, expected latencies / final word) plus randomized transfers over
// random RAM contents, and a hand-written mid-transfer reset sequence.
// Expected words come from the RAM array indexed by (base + i) mod 256.
module tb_ram_stream_reader;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    int          mode;          // 0: ready always, 1: ready 1,0,0 repeating, 2: random
    bit          repulse;       // re-pulse start mid-transfer with other arguments
    int          exp_first_k;   // cycle of first m_valid after start edge (-1: never)
    int          exp_done_k;    // cycle of done after start edge (-1: not checked)
    logic [15:0] exp_last_data; // word carrying m_last
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy, done, ben;
  logic [7:0]  addrb;
  logic [15:0] dob;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        m_last;

  logic [15:0] mem [256];
  vec_t        vecs [8];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  ram_stream_reader #(.addr_bits(8), .data_bits(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ben(ben), .addrb(addrb), .dob(dob),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // RAM port B: data one cycle after ben, garbage otherwise.
  always @(posedge clk) begin
    if (ben) dob <= mem[addrb];
    else     dob <= 16'($urandom);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    int issued = 0, accepted = 0, first_k = -1, done_k = -1, done_cnt = 0;
    int first_acc = -1, last_acc = -1, budget;
    bit prev_stall = 1'b0;
    logic [15:0] prev_data = '0, exp_word;
    logic prev_last = 1'b0;
    budget = 4 * int'(v.len) + 20;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; length = v.len; m_ready = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.repulse && k == 3) begin
        start = 1'b1; base_addr = 8'h80; length = 9'd9;
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (ben) begin
        chk("ben_within_length", issued < int'(v.len), 1);
        chk("addrb", addrb, (int'(v.base) + issued) % 256);
        issued++;
        chk("outstanding_le3", (issued - accepted) <= 3, 1);
      end
      if (m_valid && first_k < 0) first_k = k;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        chk("done_with_busy", busy, 1);
        chk("done_after_all_words", accepted, int'(v.len));
      end
      if (done_k >= 0 && k == done_k + 1) chk("busy_low_after_done", busy, 0);
      m_ready = ready_for(v.mode, k);
      if (m_valid && m_ready) begin
        exp_word = mem[(int'(v.base) + accepted) % 256];
        chk("m_data", m_data, exp_word);
        chk("m_last", m_last, accepted == int'(v.len) - 1);
        if (m_last) chk("last_data", m_data, v.exp_last_data);
        if (first_acc < 0) first_acc = k;
        last_acc = k;
        accepted++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done_k >= 0 && k == done_k + 2) break;
    end
    chk("done_seen", done_k >= 0, 1);
    chk("done_count", done_cnt, 1);
    chk("words_accepted", accepted, int'(v.len));
    chk("reads_issued", issued, int'(v.len));
    chk("first_valid_k", first_k, v.exp_first_k);
    if (v.exp_done_k >= 0) chk("done_k", done_k, v.exp_done_k);
    if (v.mode == 0 && v.len != 0) chk("no_bubbles", last_acc - first_acc, int'(v.len) - 1);
    m_ready = 1'b0;
    $display("xfer %s base=%02h len=%0d mode=%0d words=%0d reads=%0d done_k=%0d",
             tag, v.base, v.len, v.mode, accepted, issued, done_k);
  endtask

  initial begin
    vec_t rv;
    int   acc;
    vecs[0] = '{8'h10, 9'd4,   0, 1'b0,  2, -1, 16'h0013};
    vecs[1] = '{8'h10, 9'd4,   1, 1'b0,  2, -1, 16'h0013};
    vecs[2] = '{8'hFE, 9'd4,   0, 1'b0,  2, -1, 16'h0001};
    vecs[3] = '{8'h00, 9'd0,   0, 1'b0, -1,  1, 16'h0000};
    vecs[4] = '{8'h00, 9'd256, 0, 1'b0,  2, -1, 16'h00FF};
    vecs[5] = '{8'h10, 9'd4,   0, 1'b1,  2, -1, 16'h0013};
    vecs[6] = '{8'h7F, 9'd1,   1, 1'b0,  2, -1, 16'h007F};
    vecs[7] = '{8'hF0, 9'd256, 2, 1'b0,  2, -1, 16'h00EF};

    for (int i = 0; i < 256; i++) mem[i] = 16'(i);

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ben", ben, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 8; t++) run_xfer(vecs[t], $sformatf("table%0d", t));

    // Reset after two of eight words are accepted.
    @(negedge clk);
    start = 1'b1; base_addr = 8'h00; length = 9'd8; m_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) acc++;
      if (acc == 2) break;
    end
    chk("abort_two_words", acc, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ben", ben, 0);
    chk("abort_addrb", addrb, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_m_data", m_data, 0);
    chk("abort_m_last", m_last, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_no_valid", m_valid, 0);
    end
    m_ready = 1'b0;
    rv = '{8'h40, 9'd2, 0, 1'b0, 2, -1, 16'h0041};
    run_xfer(rv, "after_abort");

    // Randomized transfers over random RAM contents.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      rv.base          = 8'($urandom);
      rv.len           = (r == 0) ? 9'd256 : 9'($urandom_range(0, 40));
      rv.mode          = 2;
      rv.repulse       = (r % 2 == 1) && (rv.len >= 9'd4);
      rv.exp_first_k   = (rv.len != 0) ? 2 : -1;
      rv.exp_done_k    = (rv.len != 0) ? -1 : 1;
      rv.exp_last_data = (rv.len != 0) ? mem[(int'(rv.base) + int'(rv.len) - 1) % 256] : 16'h0;
      run_xfer(rv, $sformatf("random%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
